// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded CPU: interrupt FSM encoding, opcodes, address width.
// Also provides the handler-vector arithmetic used by the interrupt controller.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [7:0] OP_IRET = 8'hCF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEnter   = 2'd1,
    StService = 2'd2
  } irq_state_t;

  // Wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] irq_vector(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] stride,
                                                   input logic [2:0]        id);
    logic [ADDR_W-1:0] idx;
    idx = ADDR_W'(id);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of the lowest one.
module prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected pending lines, fixed-priority arbitration and a
// one-cycle entry pulse with handler vector; blocks further entry until iret.
module irq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned      N_IRQ      = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0010,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0004
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              iret,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  input  logic              gie_we,
  input  logic              gie_wdata,
  output logic              interrupt,
  output logic [ADDR_W-1:0] vector,
  output logic [2:0]        irq_id,
  output logic [N_IRQ-1:0]  pending,
  output logic              in_service
);

  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [N_IRQ-1:0]  mask_q;
  logic              gie_q;
  logic [N_IRQ-1:0]  irq_edge;
  logic [N_IRQ-1:0]  clr;
  logic [N_IRQ-1:0]  eligible;
  logic              win_valid;
  logic [2:0]        win_idx;

  irq_state_t        state_q;
  logic              interrupt_q;
  logic [ADDR_W-1:0] vector_q;
  logic [2:0]        irq_id_q;
  logic              in_service_q;

  assign irq_edge = irq & ~irq_q;
  assign eligible = pending_q & mask_q;

  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (state_q == StEnter && irq_id_q == 3'(i)) begin
        clr[i] = 1'b1;
      end
    end
  end

  // A fresh edge on the line being cleared wins over the clear.
  assign pending_d = (pending_q & ~clr) | irq_edge;

  prio_enc #(
    .N(N_IRQ)
  ) u_prio_enc (
    .req_i  (eligible),
    .valid_o(win_valid),
    .idx_o  (win_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      if (gie_we) begin
        gie_q <= gie_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      interrupt_q  <= 1'b0;
      vector_q     <= '0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gie_q && win_valid) begin
            state_q     <= StEnter;
            interrupt_q <= 1'b1;
            irq_id_q    <= win_idx;
            vector_q    <= irq_vector(VEC_BASE, VEC_STRIDE, win_idx);
          end
        end
        StEnter: begin
          state_q      <= StService;
          interrupt_q  <= 1'b0;
          in_service_q <= 1'b1;
        end
        StService: begin
          // gie is deliberately not consulted here: disabling it never aborts a handler.
          if (iret) begin
            state_q      <= StIdle;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          interrupt_q  <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt  = interrupt_q;
  assign vector     = vector_q;
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: per-cycle vector table with hand-derived expectations fed through a
// scoreboard queue, plus a latency sequence and a pulse-width monitor.
module tb_irq_ctrl;

  logic        CLK;
  logic        RST;
  logic [3:0]  irq;
  logic        iret;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        gie_we;
  logic        gie_wdata;
  logic        interrupt;
  logic [15:0] vector;
  logic [2:0]  irq_id;
  logic [3:0]  pending;
  logic        in_service;

  irq_ctrl #(
    .N_IRQ     (4),
    .VEC_BASE  (16'h0010),
    .VEC_STRIDE(16'h0004)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .irq       (irq),
    .iret      (iret),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .gie_we    (gie_we),
    .gie_wdata (gie_wdata),
    .interrupt (interrupt),
    .vector    (vector),
    .irq_id    (irq_id),
    .pending   (pending),
    .in_service(in_service)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        iret;
    logic        mwe;
    logic [3:0]  mdata;
    logic        gwe;
    logic        gdata;
    logic        e_int;
    logic [15:0] e_vec;
    logic [2:0]  e_id;
    logic [3:0]  e_pend;
    logic        e_svc;
  } vec_t;

  typedef struct {
    string       name;
    logic        e_int;
    logic [15:0] e_vec;
    logic [2:0]  e_id;
    logic [3:0]  e_pend;
    logic        e_svc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   compared = 0;
  int   failed   = 0;
  logic prev_int = 1'b0;

  function automatic void add(input logic r, input logic [3:0] i, input logic ir,
                              input logic mw, input logic [3:0] md, input logic gw,
                              input logic gd, input logic ei, input logic [15:0] ev,
                              input logic [2:0] eid, input logic [3:0] ep, input logic es);
    vec_t v;
    v.rst = r; v.irq = i; v.iret = ir; v.mwe = mw; v.mdata = md; v.gwe = gw; v.gdata = gd;
    v.e_int = ei; v.e_vec = ev; v.e_id = eid; v.e_pend = ep; v.e_svc = es;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic [3:0] i, input logic ir, input logic mw,
                       input logic [3:0] md, input logic gw, input logic gd);
    RST = r; irq = i; iret = ir; mask_we = mw; mask_wdata = md; gie_we = gw; gie_wdata = gd;
  endtask

  task automatic expect_out(input string nm, input logic ei, input logic [15:0] ev,
                            input logic [2:0] eid, input logic [3:0] ep, input logic es);
    exp_t e;
    e.name = nm; e.e_int = ei; e.e_vec = ev; e.e_id = eid; e.e_pend = ep; e.e_svc = es;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: got no expectation, want one");
      return;
    end
    e = sb.pop_front();
    compared++;
    if ({interrupt, vector, irq_id, pending, in_service} !==
        {e.e_int, e.e_vec, e.e_id, e.e_pend, e.e_svc}) begin
      failed++;
      $display("FAIL %s: got int=%0b vec=%h id=%0d pend=%b svc=%0b, want int=%0b vec=%h id=%0d pend=%b svc=%0b",
               e.name, interrupt, vector, irq_id, pending, in_service,
               e.e_int, e.e_vec, e.e_id, e.e_pend, e.e_svc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Entry pulse must never last two cycles.
  always @(negedge CLK) begin
    if (!RST) begin
      compared++;
      if (interrupt && prev_int) begin
        failed++;
        $display("FAIL int_pulse_width: got interrupt high two cycles, want single cycle");
      end
    end
    prev_int = interrupt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    drive(1'b1, 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);

    //  rst irq     iret mwe mdata   gwe gd   int vec      id pend    svc
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0000, 0); // 0 reset
    add(0, 4'b0000, 0, 1, 4'b1111, 1, 1,   0, 16'h0000, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0000, 0);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0100, 0); // 3 irq2 edge
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h0018, 2, 4'b0100, 0); // 4 enter
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0000, 0); // 7 iret
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0000, 0);
    add(0, 4'b1010, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b1010, 0); // 9 irq3+irq1
    add(0, 4'b1010, 0, 0, 4'b0000, 0, 0,   1, 16'h0014, 1, 4'b1010, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b1000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b1000, 0); // 12 iret
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h001C, 3, 4'b1000, 0); // 13 k+2 entry
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h001C, 3, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h001C, 3, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 4'b0001, 0, 0,   0, 16'h001C, 3, 4'b0000, 0); // 16 mask=0001
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0,   0, 16'h001C, 3, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h001C, 3, 4'b0010, 0); // 18 masked
    add(0, 4'b0000, 0, 1, 4'b0011, 0, 0,   0, 16'h001C, 3, 4'b0010, 0); // 19 old mask used
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h0014, 1, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0000, 1);
    add(0, 4'b0001, 0, 1, 4'b1111, 0, 0,   0, 16'h0014, 1, 4'b0001, 1); // 22 in service
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0101, 1);
    add(0, 4'b0101, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0101, 1);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0101, 1);
    add(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0101, 0);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   1, 16'h0010, 0, 4'b0101, 0); // 27 line0 first
    add(0, 4'b0101, 0, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0101, 1); // 28 set wins
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0101, 1);
    add(0, 4'b0100, 1, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0101, 0);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   1, 16'h0010, 0, 4'b0101, 0);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0100, 1);
    add(1, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0000, 0); // 33 reset in service
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0100, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0100, 0); // 35 stray iret
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 1,   0, 16'h0000, 0, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0100, 0); // 38 mask still 0
    add(0, 4'b0000, 0, 1, 4'b1111, 0, 0,   0, 16'h0000, 0, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h0018, 2, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 0,   0, 16'h0018, 2, 4'b0000, 1); // 42 gie off in svc
    add(0, 4'b0001, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0001, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0018, 2, 4'b0001, 0); // 45 gie=0 blocks
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 1,   0, 16'h0018, 2, 4'b0001, 0); // 46 old gie used
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h0010, 0, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0,   0, 16'h0010, 0, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   1, 16'h0014, 1, 4'b0010, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0000, 1); // 52 iret in enter
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0000, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 0, 0,   0, 16'h0014, 1, 4'b0001, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 0, 0,   1, 16'h0010, 0, 4'b0001, 0);
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0000, 0); // 57 reset in enter
    add(0, 4'b0001, 0, 0, 4'b0000, 0, 0,   0, 16'h0000, 0, 4'b0001, 0);

    @(negedge CLK);
    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].rst, tbl[n].irq, tbl[n].iret, tbl[n].mwe, tbl[n].mdata, tbl[n].gwe,
            tbl[n].gdata);
      expect_out($sformatf("row%0d", n), tbl[n].e_int, tbl[n].e_vec, tbl[n].e_id,
                 tbl[n].e_pend, tbl[n].e_svc);
      tick();
      check_pop();
    end

    // Latency from sampled edge to entry pulse, with line 0 pending but masked off.
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    expect_out("lat_entry", 1'b1, 16'h001C, 3'd3, 4'b1001, 1'b0);
    waited = 0;
    do begin
      tick();
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      waited++;
    end while (!interrupt && waited < 6);
    check_pop();
    compared++;
    if (waited != 2) begin
      failed++;
      $display("FAIL lat_cycles: got %0d cycles, want 2", waited);
    end
    expect_out("lat_service", 1'b0, 16'h001C, 3'd3, 4'b0001, 1'b1);
    tick();
    check_pop();
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    expect_out("lat_iret", 1'b0, 16'h001C, 3'd3, 4'b0001, 1'b0);
    tick();
    check_pop();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    expect_out("lat_masked_idle", 1'b0, 16'h001C, 3'd3, 4'b0001, 1'b0);
    tick();
    check_pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the CPU's microcoded control unit. It edge-detects up to `N_IRQ` external request lines and latches them as pending. It arbitrates them by fixed priority and sequences interrupt entry: it raises `interrupt` for exactly one cycle, which suppresses `JMP`/`PCpp` in the control unit, and presents the handler vector. It then blocks further entry until the handler executes `iret`.

## Interface

Parameters:
- `N_IRQ`, 4: number of request lines, 1..8.
- `VEC_BASE`, 16'h0010: address of the handler for line 0.
- `VEC_STRIDE`, 16'h0004: address distance between consecutive handlers.

Ports (clock and reset first):
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `irq` input N_IRQ: request lines, level inputs, already synchronous to `CLK`; rising edge = request.
- `iret` input 1: one-cycle pulse from the control unit when the return-from-interrupt opcode executes.
- `mask_we` input 1: write strobe for the enable mask.
- `mask_wdata` input N_IRQ: new mask value; bit=1 enables the line.
- `gie_we` input 1: write strobe for the global enable.
- `gie_wdata` input 1: new global enable value.
- `interrupt` output 1: entry pulse to the control unit.
- `vector` output 16: handler address; valid while `interrupt`=1.
- `irq_id` output 3: index of the line being or last serviced.
- `pending` output N_IRQ: latched pending bits.
- `in_service` output 1: high from entry until `iret`.

## Operation

- Edge detect:
  - `irq_q` holds `irq` delayed by one cycle.
  - `edge = irq & ~irq_q`; each edge bit sets its `pending` bit.
  - Pending bits stay latched regardless of mask.
- Eligible lines: `pending & mask`. A line is eligible only when `gie`=1. Priority is fixed: the lowest index wins.
- FSM states: IDLE, ENTER, SERVICE.
  - IDLE → ENTER when `gie` and any line is eligible. The winner is captured in `irq_id`.
  - ENTER lasts exactly one cycle:
    - `interrupt`=1.
    - `vector = VEC_BASE + irq_id*VEC_STRIDE`, computed modulo 2^16.
    - The pending bit of `irq_id` is cleared.
    - Next state is SERVICE.
  - SERVICE: `in_service`=1. On `iret`, go to IDLE. No nesting.
- `iret` received in IDLE or ENTER is ignored.
- Simultaneous events:
  - A new edge on the same line in the cycle that clears its bit: the set wins and the bit stays 1.
  - `mask_we` or `gie_we` in the same cycle as arbitration: arbitration uses the old values; the new values apply from the next cycle.
  - Clearing `gie` during SERVICE does not abort the handler.
- Reset values:
  - `pending`=0, `mask`=0, `gie`=0, `irq_q`=0.
  - State = IDLE, `interrupt`=0, `vector`=0, `irq_id`=0, `in_service`=0.
- A reset in any state, including mid-ENTER or SERVICE, returns the block to the reset values on the next edge. Requests in flight are lost.

## Timing

- `irq` rises before edge t. `pending` is set after edge t. ENTER is entered after edge t+1, so `interrupt` is high during cycle t+2. Latency is 2 cycles from sample to entry pulse.
- `vector` and `irq_id` are registered. They are stable for the whole ENTER cycle. `vector` holds its value afterwards until the next ENTER.
- `interrupt` never stays high for two consecutive cycles. The minimum spacing between two entries is ENTER, SERVICE (≥1 cycle), IDLE (1 cycle).
- `iret` in cycle k moves the FSM to IDLE after edge k. The earliest next `interrupt` is cycle k+2.
- A mask or gie write in cycle k is visible to arbitration in cycle k+1.

## Structure

- Shared package `cpu_pkg`:
  - FSM state encoding `irq_state_t` (IDLE=2'd0, ENTER=2'd1, SERVICE=2'd2).
  - Opcode constant for `iret` decode, used by the control unit.
  - `ADDR_W`=16.
- One sub-module, `prio_enc`: parameterised fixed-priority encoder. It takes an N-bit request and outputs `valid` plus a 3-bit index (lowest set bit).
- Everything else, including edge detect, pending/mask/gie registers, FSM and vector multiply-add, lives flat in `irq_ctrl`.

## Test plan

- Reset, then set `mask`=4'b1111 and `gie`=1. Pulse `irq[2]` at cycle 10. Expect `interrupt`=1 only at cycle 12, with `vector`=16'h0018, `irq_id`=2, `pending[2]` cleared, then `in_service`=1. Pulse `iret`; expect `in_service`=0 the next cycle.
- Raise `irq[3]` and `irq[1]` in the same cycle. Expect the first entry with `vector`=16'h0014. After `iret`, expect the second entry with `vector`=16'h001C, at the earliest 2 cycles after `iret`.
- With `mask`=4'b0001, pulse `irq[1]`. Expect no `interrupt` and `pending`=4'b0010. Write `mask`=4'b0011; expect `interrupt` one cycle after the write cycle with `irq_id`=1.
- During SERVICE, pulse `irq[0]` twice and hold `irq[2]` high. Expect `pending`=4'b0101 and no `interrupt` until after `iret`. Then expect line 0 to be serviced first.
- Re-edge `irq[0]` in the exact ENTER cycle servicing line 0. Expect `pending[0]`=1 afterwards.
- Assert `RST` during SERVICE with bits pending. Expect all outputs zero next cycle and no `interrupt` until the mask and gie are rewritten. A stray `iret` in IDLE causes no state change.
